counter_bank: RTL

Parametrised bank of CH independent synchronous up/down counters sharing one clock and one asynchronous active-low reset. It is the next generation of the 3-bit ripple up-counter and down-counter pair. Each channel has run-time direction, enable, parallel load, a programmable wrap limit and a registered wrap flag. It sits wherever the design needs event counters, dividers or modulo sequencers.

---
 rtl/counter_bank_pkg.sv | 17 +
 rtl/counter_bank_if.sv | 22 ++
 rtl/updn_channel.sv | 80 ++++++++
 rtl/counter_bank.sv | 37 +++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
// Shared constants and helpers for the counter bank.
//   DIR_UP / DIR_DN : values of a channel's dir input
//   clamp()         : min(value, limit), used to keep loaded values in range
package counter_bank_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Works on 32-bit operands so any channel width up to 31 bits can use it;
   // the caller narrows the result back to its own width.
   function automatic logic [31:0] clamp(input logic [31:0] value,
                                         input logic [31:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/counter_bank_if.sv
// counter_bank_if
// Bundles the per-channel control and result buses of counter_bank.
//   en, dir, load : CH bits, one per channel
//   load_val, q   : CH*W bits, channel i in [i*W +: W]
//   wrap          : CH bits, registered wrap/saturation flags
// master drives the controls and reads results; slave is the counter bank.
interface counter_bank_if #(
   parameter int W  = 3,
   parameter int CH = 2
);
   logic [CH-1:0]   en;
   logic [CH-1:0]   dir;
   logic [CH-1:0]   load;
   logic [CH*W-1:0] load_val;
   logic [CH*W-1:0] q;
   logic [CH-1:0]   wrap;

   modport master (output en, output dir, output load, output load_val,
                   input q, input wrap);
   modport slave  (input en, input dir, input load, input load_val,
                   output q, output wrap);
endinterface

// File: rtl/updn_channel.sv
// updn_channel
// One W-bit up/down counter running modulo MAX+1.
//   clk, reset (async, active-low)
//   en, dir (1 = up), load, load_val[W-1:0]
//   q[W-1:0]  registered count, never above MAX
//   wrap      registered flag, high in the cycle q shows a wrapped value
// Build option COUNTER_BANK_SAT_EN: saturate at 0 / MAX instead of wrapping;
// wrap then flags every enabled cycle that tries to pass the limit.
module updn_channel
   import counter_bank_pkg::*;
#(
   parameter int W   = 3,
   parameter int MAX = 2**W-1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         dir,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q,
   output logic         wrap
);

   localparam logic [W:0]   MAX_X = (W+1)'(MAX);
   localparam logic [W-1:0] MAX_Q = W'(MAX);

   logic [W:0]   q_x;
   logic [W-1:0] q_next;
   logic         wrap_next;

   // One extra bit of headroom so +1 at 2**W-1 and -1 at 0 stay in range.
   assign q_x = {1'b0, q};

   // Next-state selection: load beats enable, enable beats hold.
   // wrap defaults low so it only ever lasts the single cycle of a limit hit.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         q_next = W'(clamp(32'(load_val), 32'(MAX)));
      end else if (en) begin
         if (dir == DIR_UP) begin
            if (q_x >= MAX_X) begin
               wrap_next = 1'b1;
`ifdef COUNTER_BANK_SAT_EN
               q_next    = MAX_Q;
`else
               q_next    = '0;
`endif
            end else begin
               q_next = W'(q_x + (W+1)'(1));
            end
         end else begin
            if (q_x == '0) begin
               wrap_next = 1'b1;
`ifdef COUNTER_BANK_SAT_EN
               q_next    = '0;
`else
               q_next    = MAX_Q;
`endif
            end else begin
               q_next = W'(q_x - (W+1)'(1));
            end
         end
      end
   end

   // Count and flag registers; reset clears both without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: rtl/counter_bank.sv
// counter_bank
// CH independent up/down counters sharing one clock and reset.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low clear of every channel
//   bus    : counter_bank_if slave (en, dir, load, load_val in; q, wrap out)
// Parameters: W bits per channel, CH channels, MAX terminal count.
// Build option COUNTER_BANK_SAT_EN selects saturating instead of wrapping.
module counter_bank
   import counter_bank_pkg::*;
#(
   parameter int W   = 3,
   parameter int CH  = 2,
   parameter int MAX = 2**W-1
) (
   input  logic           clk,
   input  logic           reset,
   counter_bank_if.slave  bus
);

   // Each channel owns its own slice of the packed buses; nothing is shared.
   for (genvar i = 0; i < CH; i++) begin : g_ch
      updn_channel #(
         .W   (W),
         .MAX (MAX)
      ) u_channel (
         .clk      (clk),
         .reset    (reset),
         .en       (bus.en[i]),
         .dir      (bus.dir[i]),
         .load     (bus.load[i]),
         .load_val (bus.load_val[i*W +: W]),
         .q        (bus.q[i*W +: W]),
         .wrap     (bus.wrap[i])
      );
   end

endmodule
